// File: rtl/stdp_weight_updater.sv
// Read-modify-write controller applying a shift-based exponential STDP delta to one synaptic weight.
// Optional feature macro: STDP_UPD_SAT_STATS_EN builds the saturating sat_count statistics counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a request; req_ready high
// S_READ  | RAM read address presented; RAM registers the weight
// S_CALC  | registered weight available; new weight computed and latched
// S_WRITE | new weight written back; upd_done pulses
module stdp_weight_updater #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4,
    parameter int DT_WIDTH   = 8,
    parameter int TAU_LOG2   = 2,
    parameter int A_PLUS     = 64,
    parameter int A_MINUS    = 48,
    parameter int W_MIN      = 0,
    parameter int W_MAX      = 8191
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic signed [DT_WIDTH-1:0]   req_dt,
    output logic [ADDR_WIDTH-1:0]        ram_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH-1:0]        ram_wr_addr,
    output logic signed [DATA_WIDTH-1:0] ram_wr_data,
    output logic                         ram_we,
    output logic                         upd_done,
    output logic signed [DATA_WIDTH-1:0] upd_weight,
    output logic                         busy,
    output logic [15:0]                  sat_count
);

    localparam int SW = DATA_WIDTH + 2;
    localparam logic signed [SW-1:0] W_MIN_S = SW'(W_MIN);
    localparam logic signed [SW-1:0] W_MAX_S = SW'(W_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CALC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic signed [DT_WIDTH-1:0]     dt_q, dt_d;
    logic signed [DATA_WIDTH-1:0]   wnew_q, wnew_d;

    logic signed [DT_WIDTH:0]       dt_ext;
    logic [DT_WIDTH:0]              mag;
    logic [DT_WIDTH:0]              shift;
    logic [SW-1:0]                  amp_plus;
    logic [SW-1:0]                  amp_minus;
    logic signed [SW-1:0]           delta;
    logic signed [SW-1:0]           weight_ext;
    logic signed [SW-1:0]           sum;
    logic                           sat_under;
    logic                           sat_over;
    logic signed [DATA_WIDTH-1:0]   clamped;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dt_q    <= '0;
            wnew_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dt_q    <= dt_d;
            wnew_q  <= wnew_d;
        end
    end

    // The extra bit keeps |dt| exact for the most negative dt value.
    always_comb begin
        dt_ext    = {dt_q[DT_WIDTH-1], dt_q};
        mag       = dt_ext[DT_WIDTH] ? unsigned'(-dt_ext) : unsigned'(dt_ext);
        shift     = mag >> TAU_LOG2;
        amp_plus  = SW'(A_PLUS) >> shift;
        amp_minus = SW'(A_MINUS) >> shift;
        delta     = '0;
        if (32'(shift) < 32'd16) begin
            if (dt_ext[DT_WIDTH]) begin
                delta = -signed'(amp_minus);
            end else if (dt_ext != '0) begin
                delta = signed'(amp_plus);
            end
        end
        weight_ext = {{2{ram_rd_data[DATA_WIDTH-1]}}, ram_rd_data};
        sum        = weight_ext + delta;
        sat_under  = (sum < W_MIN_S);
        sat_over   = (sum > W_MAX_S);
        if (sat_under) begin
            clamped = DATA_WIDTH'(W_MIN);
        end else if (sat_over) begin
            clamped = DATA_WIDTH'(W_MAX);
        end else begin
            clamped = sum[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dt_d    = dt_q;
        wnew_d  = wnew_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = S_READ;
                    addr_d  = req_addr;
                    dt_d    = req_dt;
                end
            end
            S_READ:  state_d = S_CALC;
            S_CALC: begin
                state_d = S_WRITE;
                wnew_d  = clamped;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ram_rd_addr = addr_q;
    assign ram_wr_addr = addr_q;
    assign ram_wr_data = wnew_q;
    assign upd_weight  = wnew_q;
    // A synchronous reset landing in WRITE must not let the RAM commit on that edge.
    assign ram_we      = (state_q == S_WRITE) && !rst;
    assign upd_done    = (state_q == S_WRITE) && !rst;

`ifdef STDP_UPD_SAT_STATS_EN
    logic        sat_q, sat_d;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_d     = sat_q;
        sat_cnt_d = sat_cnt_q;
        if (state_q == S_CALC) begin
            sat_d = sat_under || sat_over;
        end
        if ((state_q == S_WRITE) && sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_q     <= sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = 16'd0;
`endif

endmodule

// File: tb/tb_stdp_weight_updater.sv
// Directed bench for stdp_weight_updater with a behavioural 1-cycle-latency weight RAM.
module tb_stdp_weight_updater;

`ifdef STDP_UPD_SAT_STATS_EN
    localparam int SAT_EN = 1;
`else
    localparam int SAT_EN = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [3:0]         req_addr;
    logic signed [7:0]  req_dt;
    logic [3:0]         ram_rd_addr;
    logic signed [17:0] ram_rd_data = '0;
    logic [3:0]         ram_wr_addr;
    logic signed [17:0] ram_wr_data;
    logic               ram_we;
    logic               upd_done;
    logic signed [17:0] upd_weight;
    logic               busy;
    logic [15:0]        sat_count;

    logic signed [17:0] mem [16] = '{default: '0};
    int                 wr_count = 0;
    logic               pre_we;
    logic [3:0]         pre_addr;
    logic signed [17:0] pre_data;

    int n_chk = 0;
    int n_err = 0;
    int wc0;

    stdp_weight_updater dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_dt      (req_dt),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_we      (ram_we),
        .upd_done    (upd_done),
        .upd_weight  (upd_weight),
        .busy        (busy),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_wr_addr] <= ram_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic signed [17:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", req_ready, 1);
    endtask

    task automatic run_update(input logic [3:0] a, input logic signed [7:0] dt, input longint exp);
        wait_ready();
        req_addr  = a;
        req_dt    = dt;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = ~a;
        req_dt    = -dt;
        chk("read_busy", busy, 1);
        chk("read_ready", req_ready, 0);
        chk("read_addr", ram_rd_addr, a);
        chk("read_we", ram_we, 0);
        @(negedge clk);
        chk("calc_we", ram_we, 0);
        @(negedge clk);
        chk("wr_we", ram_we, 1);
        chk("wr_done", upd_done, 1);
        chk("wr_addr", ram_wr_addr, a);
        chk("wr_data", ram_wr_data, exp);
        chk("upd_weight", upd_weight, exp);
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        chk("idle_we", ram_we, 0);
        chk("ram_value", mem[a], exp);
    endtask

    task automatic check_reset_values();
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_done", upd_done, 0);
        chk("rst_weight", upd_weight, 0);
        chk("rst_rd_addr", ram_rd_addr, 0);
        chk("rst_wr_addr", ram_wr_addr, 0);
        chk("rst_wr_data", ram_wr_data, 0);
        chk("rst_sat", sat_count, 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_dt    = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        // potentiation / depression, including zero-delta cases
        preload(3, 1000);
        run_update(3, 8'sd4, 1032);
        preload(5, 1000);
        run_update(5, -8'sd1, 952);
        run_update(5, 8'sh80, 952);
        preload(6, 2000);
        run_update(6, -8'sd7, 1976);
        run_update(6, 8'sd12, 1984);
        run_update(6, 8'sd63, 1984);
        chk("sat_none", sat_count, 0);

        // saturation at both clamps
        preload(7, 8180);
        run_update(7, 8'sd1, 8191);
        chk("sat_hi", sat_count, SAT_EN * 1);
        preload(8, 10);
        run_update(8, -8'sd2, 0);
        chk("sat_lo", sat_count, SAT_EN * 2);

        // back-to-back to the same address with req_valid held
        preload(2, 500);
        wait_ready();
        req_addr  = 4'd2;
        req_dt    = 8'sd1;
        req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_wr1", ram_wr_data, 564);
        @(negedge clk);
        chk("b2b_ready_c4", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_accept2", busy, 1);
        @(negedge clk);
        chk("b2b_rd2", ram_rd_data, 564);
        @(negedge clk);
        chk("b2b_wr2", ram_wr_data, 628);
        @(negedge clk);
        chk("b2b_final", mem[2], 628);

        // reset during CALC drops the update
        preload(4, 200);
        wc0 = wr_count;
        wait_ready();
        req_addr  = 4'd4;
        req_dt    = 8'sd4;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_write", wr_count - wc0, 0);
        chk("rst_ram_kept", mem[4], 200);
        run_update(4, 8'sd4, 232);

        // request held while busy: only values present at req_ready are taken
        preload(9, 100);
        preload(10, 777);
        preload(11, 300);
        wc0 = wr_count;
        wait_ready();
        req_addr  = 4'd9;
        req_dt    = 8'sd4;
        req_valid = 1'b1;
        @(negedge clk);
        req_addr = 4'd10;
        req_dt   = -8'sd1;
        @(negedge clk);
        req_addr = 4'd12;
        req_dt   = 8'sd5;
        @(negedge clk);
        chk("hold_wr_addr1", ram_wr_addr, 9);
        chk("hold_wr_data1", ram_wr_data, 132);
        req_addr = 4'd11;
        req_dt   = 8'sd8;
        @(negedge clk);
        @(negedge clk);
        chk("hold_rd_addr2", ram_rd_addr, 11);
        req_addr  = 4'd10;
        req_dt    = -8'sd1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold_wr_data2", ram_wr_data, 316);
        @(negedge clk);
        chk("hold_mem9", mem[9], 132);
        chk("hold_mem10", mem[10], 777);
        chk("hold_mem11", mem[11], 316);
        chk("hold_writes", wr_count - wc0, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/stdp_weight_updater.md
# stdp_weight_updater

Read-modify-write controller for the synaptic weight memory of the STDP learning engine. It accepts one weight-update request at a time, consisting of a synapse address and a signed spike-time difference. It reads the current weight from the dual-port weight RAM, applies a shift-based exponential STDP delta with saturation, and writes the result back. It sits directly upstream of the weight RAM, drives that RAM's read/write address, write data and write enable, and consumes its registered read data.

## Interface
- DATA_WIDTH, 18, signed weight width; matches the weight RAM.
- ADDR_WIDTH, 4, synapse address width.
- DT_WIDTH, 8, signed spike-time difference width (t_post − t_pre).
- TAU_LOG2, 2, each 2^TAU_LOG2 units of |dt| halve the delta.
- A_PLUS, 64, potentiation amplitude (positive).
- A_MINUS, 48, depression amplitude (positive).
- W_MIN, 0, lower weight clamp (signed).
- W_MAX, 8191, upper weight clamp (signed).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  update request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH  synapse address.
- req_dt  in  DT_WIDTH  signed spike-time difference.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  DATA_WIDTH  signed RAM read data; 1-cycle registered latency.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  DATA_WIDTH  signed RAM write data.
- ram_we  out  1  RAM write enable.
- upd_done  out  1  one-cycle pulse when the write is issued.
- upd_weight  out  DATA_WIDTH  new weight; valid while upd_done is high.
- busy  out  1  high in any state other than IDLE.
- sat_count  out  16  count of saturation events (see Configuration).

## Operation
- FSM states: IDLE → READ → CALC → WRITE → IDLE. Every transition is unconditional except IDLE→READ, which requires req_valid && req_ready.
- On acceptance: latch req_addr into addr_q and req_dt into dt_q.
- READ: ram_rd_addr = addr_q. The RAM registers the data at the end of this cycle.
- CALC: capture ram_rd_data and compute the delta and new weight into registers.
  - mag = |dt_q|; shift = mag >> TAU_LOG2.
  - dt_q > 0: delta = +(A_PLUS >> shift).
  - dt_q < 0: delta = −(A_MINUS >> shift).
  - dt_q == 0, or shift ≥ 16: delta = 0.
  - |dt_q| for the most negative DT_WIDTH value is computed without overflow, using a DT_WIDTH+1 bit width.
  - sum = weight + delta, computed at DATA_WIDTH+2 bits signed.
  - Clamp sum to [W_MIN, W_MAX]. A clamp that actually changes the value is a saturation event.
- WRITE:
  - ram_we = 1, ram_wr_addr = addr_q, ram_wr_data = new weight.
  - upd_done = 1, upd_weight = new weight.
  - The write occurs even when delta = 0.
- ram_rd_addr and ram_wr_addr hold addr_q in every non-IDLE state. ram_we is high only in WRITE.

## Timing
- Acceptance edge is cycle 0. READ is cycle 1, CALC is cycle 2, WRITE is cycle 3 (ram_we, upd_done), and the FSM is back in IDLE in cycle 4.
- Throughput is one update per 4 cycles. req_ready rises in the cycle after WRITE.
- Back-to-back requests to the same address are hazard-free. The write lands at the end of WRITE, and the next READ occurs no earlier than 2 cycles later, so it returns the updated weight.
- All outputs are registered or decoded from state only; there is no combinational path from req_* to ram_*.
- Reset values: state = IDLE, req_ready = 1, busy = 0, ram_we = 0, upd_done = 0, upd_weight = 0, ram_rd_addr = 0, ram_wr_addr = 0, ram_wr_data = 0, sat_count = 0.
- Reset asserted mid-operation (READ, CALC or WRITE):
  - The in-flight update is dropped.
  - No RAM write occurs on the reset edge or afterwards.
  - The FSM is in IDLE on the cycle after reset.
- req_valid while busy is ignored; the requester must hold the request until req_ready.

## Configuration
- STDP_UPD_SAT_STATS_EN defined: sat_count increments by 1 in WRITE when the committed update saturated. It holds at 16'hFFFF rather than wrapping, and is cleared only by rst.
- STDP_UPD_SAT_STATS_EN undefined: no counter logic is built and sat_count is tied to 0. All other behaviour is identical.

## Test plan
- RAM[3] = 1000, req addr 3, dt = +4 (shift 1): ram_we in cycle 3 with data 1032, upd_done = 1, RAM[3] = 1032.
- RAM[5] = 1000, dt = −1 (shift 0): write 952. Then dt = −128: delta = 0, so 952 is written back unchanged.
- RAM[7] = 8180, dt = +1: result clamps to 8191 and sat_count = 1 with the macro defined (0 without). RAM[8] = 10, dt = −2: result clamps to 0 and sat_count = 2.
- RAM[2] = 500, two back-to-back requests to addr 2 with dt = +1 then dt = +1: second read returns 564, final value 628, second req_ready 4 cycles after the first acceptance.
- Assert rst during CALC of an update to addr 4 (RAM[4] = 200): ram_we never rises, RAM[4] stays 200, all outputs show reset values, and the next request is accepted normally.
- req_valid held high continuously with changing addr/dt while busy: only the values present at req_ready are latched, and exactly one write occurs per acceptance.
